// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared constants and types for the fetch stage
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer holding {instruction, pc} entries
import rv32i_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push into a full buffer is fine then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, imem request issue, response buffering and redirect drain
import rv32i_pkg::*;

module fetch_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INSTRUCTION = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTRUCTION-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [DATA_WIDTH-1:0]  redirect_pc,
  input  logic                   stall,
  output logic                   instr_valid,
  output logic [INSTRUCTION-1:0] instruction,
  output logic [DATA_WIDTH-1:0]  pc_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INSTRUCTION + DATA_WIDTH;

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_q, drop_d;

  logic [DATA_WIDTH-1:0] pc_queue [FIFO_DEPTH];
  logic [AW-1:0]         pq_wr, pq_rd;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_empty, fifo_full;
  logic [CW-1:0]         fifo_count;
  logic [EW-1:0]         fifo_din, fifo_dout;

  logic                  redirect_take, credit_ok, req_fire, rsp_accept;

  assign redirect_take = redirect_valid && (state_q != BOOT);
  // Buffered plus in-flight never exceeds the buffer, so every response has a slot.
  assign credit_ok     = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(FIFO_DEPTH);
  assign req_fire      = imem_req && imem_gnt;
  assign rsp_accept    = imem_rvalid && (outstanding_q != '0);
  assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_accept);

  assign fifo_push  = (state_q == RUN) && !redirect_take && rsp_accept;
  assign fifo_pop   = instr_valid && !stall;
  assign fifo_flush = redirect_take;
  assign fifo_din   = {imem_rdata, pc_queue[pq_rd]};
  assign imem_addr  = pc_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_take) begin
          // Responses still owed by memory belong to the abandoned path.
          drop_d  = outstanding_d;
          state_d = (outstanding_d != '0) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (rsp_accept && (drop_q != '0)) drop_d = drop_q - 1'b1;
        state_d = (drop_d == '0) ? RUN : DRAIN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == RUN) && credit_ok && !redirect_valid;
    instr_valid = !fifo_empty;
    instruction = instr_valid ? fifo_dout[EW-1:DATA_WIDTH] : INSTRUCTION'(NOP_INSTR);
    pc_out      = instr_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      pq_wr         <= '0;
      pq_rd         <= '0;
    end else begin
      if (redirect_take)  pc_q <= redirect_pc & ~DATA_WIDTH'(3);
      else if (req_fire)  pc_q <= pc_q + DATA_WIDTH'(PC_STEP);
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      // The PC queue keeps advancing across redirects so discards stay aligned.
      if (req_fire)   pq_wr <= pq_wr + 1'b1;
      if (rsp_accept) pq_rd <= pq_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_queue[pq_wr] <= pc_q;
  end

  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop));
  assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  exp_t        exp_q[$];
  logic [31:0] resp_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] model_pc;
  logic        gnt_en;
  logic        resp_en;
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_instr, obs_pc;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .DATA_WIDTH  (32),
    .INSTRUCTION (32),
    .RESET_PC    (32'h0000_0000),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .pc_out         (pc_out)
  );

  // One clock cycle: memory drives, outputs are observed, scoreboard updated.
  task automatic cycle();
    exp_t        e;
    logic [31:0] a;
    imem_gnt = gnt_en;
    if (resp_en && resp_q.size() > 0) begin
      a           = resp_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = a ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = instr_valid;
    obs_instr = instruction;
    obs_pc    = pc_out;
    if (!rst) begin
      if (imem_req && imem_gnt) resp_q.push_back(imem_addr);
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (instr_valid && !stall) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got pc %h instr %h want no instruction", pc_out, instruction);
          end else begin
            e = exp_q.pop_front();
            if (instruction !== e.instr || pc_out !== e.pc)
              $display("FAIL sb_entry: got pc %h instr %h want pc %h instr %h", pc_out, instruction, e.pc, e.instr);
            else n_pass++;
          end
          pop_log.push_back(pc_out);
        end
        if (imem_req && imem_gnt) begin
          e.pc    = model_pc;
          e.instr = model_pc ^ KEY;
          exp_q.push_back(e);
          model_pc = model_pc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    model_pc = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", imem_addr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
    n_checks++; if (instruction !== NOP) $display("FAIL reset_instr: got %h want %h", instruction, NOP); else n_pass++;
    n_checks++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out: got %h want 00000000", pc_out); else n_pass++;
    rst = 1'b0;
    cycle();
    n_checks++; if (obs_req !== 1'b0) $display("FAIL boot_no_req: got %b want 0", obs_req); else n_pass++;
    cycle();
    n_checks++; if (obs_req !== 1'b1) $display("FAIL first_req: got %b want 1", obs_req); else n_pass++;
    n_checks++; if (obs_addr !== 32'h0) $display("FAIL first_addr: got %h want 00000000", obs_addr); else n_pass++;
  endtask

  task automatic test_stream();
    pop_log.delete();
    for (int i = 0; i < 40 && pop_log.size() < 4; i++) cycle();
    n_checks++;
    if (pop_log.size() < 4) begin
      $display("FAIL stream_count: got %0d want 4", pop_log.size());
    end else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (pop_log[k] !== 32'(4 * k)) $display("FAIL stream_pc%0d: got %h want %h", k, pop_log[k], 32'(4 * k));
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc;
    stall = 1'b1;
    repeat (6) cycle();
    held_pc = (exp_q.size() > 0) ? exp_q[0].pc : 32'hDEAD_BEEF;
    n_checks++; if (obs_req !== 1'b0) $display("FAIL stall_req: got %b want 0", obs_req); else n_pass++;
    n_checks++; if (obs_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", obs_valid); else n_pass++;
    n_checks++; if (obs_instr !== (held_pc ^ KEY)) $display("FAIL stall_instr: got %h want %h", obs_instr, held_pc ^ KEY); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (obs_pc !== held_pc) $display("FAIL stall_hold%0d: got %h want %h", i, obs_pc, held_pc); else n_pass++;
    end
    stall = 1'b0;
    pop_log.delete();
    for (int i = 0; i < 20 && pop_log.size() < 2; i++) cycle();
    n_checks++;
    if (pop_log.size() < 2) $display("FAIL stall_release: got %0d pops want 2", pop_log.size());
    else if (pop_log[0] !== held_pc || pop_log[1] !== held_pc + 32'd4)
      $display("FAIL stall_release: got %h %h want %h %h", pop_log[0], pop_log[1], held_pc, held_pc + 32'd4);
    else n_pass++;
  endtask

  task automatic test_gnt_wait();
    gnt_en = 1'b0;
    repeat (4) cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++; if (obs_req !== 1'b1) $display("FAIL wait_req%0d: got %b want 1", i, obs_req); else n_pass++;
      n_checks++; if (obs_addr !== model_pc) $display("FAIL wait_addr%0d: got %h want %h", i, obs_addr, model_pc); else n_pass++;
      n_checks++; if (obs_valid !== 1'b0 || obs_instr !== NOP)
        $display("FAIL wait_nop%0d: got %b/%h want 0/%h", i, obs_valid, obs_instr, NOP); else n_pass++;
    end
    gnt_en = 1'b1;
    pop_log.delete();
    for (int i = 0; i < 20 && pop_log.size() < 2; i++) cycle();
    n_checks++; if (pop_log.size() < 2) $display("FAIL wait_resume: got %0d pops want 2", pop_log.size()); else n_pass++;
  endtask

  task automatic test_redirect();
    resp_en = 1'b0;
    repeat (6) cycle();
    n_checks++; if (obs_req !== 1'b0) $display("FAIL redir_credit: got %b want 0", obs_req); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    cycle();
    n_checks++; if (obs_req !== 1'b0) $display("FAIL redir_cycle_req: got %b want 0", obs_req); else n_pass++;
    redirect_valid = 1'b0; resp_en = 1'b1;
    cycle();
    n_checks++; if (obs_req !== 1'b0) $display("FAIL redir_drain1: got %b want 0", obs_req); else n_pass++;
    cycle();
    n_checks++; if (obs_req !== 1'b0) $display("FAIL redir_drain2: got %b want 0", obs_req); else n_pass++;
    pop_log.delete();
    cycle();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h100)
      $display("FAIL redir_resume: got %b/%h want 1/00000100", obs_req, obs_addr); else n_pass++;
    for (int i = 0; i < 20 && pop_log.size() < 1; i++) cycle();
    n_checks++;
    if (pop_log.size() < 1) $display("FAIL redir_first_pc: got no pop want 00000100");
    else if (pop_log[0] !== 32'h100) $display("FAIL redir_first_pc: got %h want 00000100", pop_log[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    resp_en = 1'b0;
    repeat (6) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect_pc = 32'h300;
    cycle();
    n_checks++; if (obs_req !== 1'b0) $display("FAIL b2b_redir_req: got %b want 0", obs_req); else n_pass++;
    redirect_valid = 1'b0; resp_en = 1'b1;
    cycle();
    n_checks++; if (obs_req !== 1'b0 || obs_addr !== 32'h300)
      $display("FAIL b2b_drain1: got %b/%h want 0/00000300", obs_req, obs_addr); else n_pass++;
    cycle();
    n_checks++; if (obs_req !== 1'b0) $display("FAIL b2b_drain2: got %b want 0", obs_req); else n_pass++;
    pop_log.delete();
    cycle();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h300)
      $display("FAIL b2b_resume: got %b/%h want 1/00000300", obs_req, obs_addr); else n_pass++;
    for (int i = 0; i < 20 && pop_log.size() < 2; i++) cycle();
    n_checks++;
    if (pop_log.size() < 2) $display("FAIL b2b_seq: got %0d pops want 2", pop_log.size());
    else if (pop_log[0] !== 32'h300 || pop_log[1] !== 32'h304)
      $display("FAIL b2b_seq: got %h %h want 00000300 00000304", pop_log[0], pop_log[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    repeat (6) cycle();
    n_checks++; if (obs_valid !== 1'b1 || obs_req !== 1'b0)
      $display("FAIL mid_full: got valid %b req %b want 1 0", obs_valid, obs_req); else n_pass++;
    #2;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL mid_req: got %b want 0", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL mid_addr: got %h want 00000000", imem_addr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0 || instruction !== NOP)
      $display("FAIL mid_out: got %b/%h want 0/%h", instr_valid, instruction, NOP); else n_pass++;
    n_checks++; if (pc_out !== 32'h0) $display("FAIL mid_pc_out: got %h want 00000000", pc_out); else n_pass++;
    exp_q.delete(); resp_q.delete(); model_pc = 32'h0; stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle();
    n_checks++; if (obs_req !== 1'b0) $display("FAIL mid_boot: got %b want 0", obs_req); else n_pass++;
    pop_log.delete();
    cycle();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0)
      $display("FAIL mid_restart: got %b/%h want 1/00000000", obs_req, obs_addr); else n_pass++;
    for (int i = 0; i < 20 && pop_log.size() < 2; i++) cycle();
    n_checks++;
    if (pop_log.size() < 2) $display("FAIL mid_seq: got %0d pops want 2", pop_log.size());
    else if (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4)
      $display("FAIL mid_seq: got %h %h want 00000000 00000004", pop_log[0], pop_log[1]);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_gnt_wait();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
